// File: rtl/karatsuba_233bit_seq_ctrl.sv
// ============================================================================
// Module   : karatsuba_233bit_seq_ctrl
// Purpose  : Sequences one N-bit GF(2) polynomial multiply through a single
//            shared H-bit sub-multiplier using three Karatsuba sub-products
//            (LO, HI, MID) folded into an accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module karatsuba_233bit_seq_ctrl #(
  parameter int N = 233,
  parameter int H = (N + 1) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  output logic             busy,
  output logic             done,
  output logic [2*N-2:0]   result,
  output logic             sub_valid,
  output logic [H-1:0]     sub_a,
  output logic [H-1:0]     sub_b,
  input  logic             sub_ready,
  input  logic             sub_p_valid,
  input  logic [2*H-2:0]   sub_p
);

  // Full product width.  The natural Karatsuba accumulator is 4H-1 bits, but
  // every bit above 2N-2 is provably zero (both high halves are zero-extended),
  // so only the RW low bits are stored.
  localparam int RW = 2 * N - 1;
  localparam int PW = 2 * H - 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_LO   = 3'd1,
    WAIT_LO  = 3'd2,
    REQ_HI   = 3'd3,
    WAIT_HI  = 3'd4,
    REQ_MID  = 3'd5,
    WAIT_MID = 3'd6,
    FINISH   = 3'd7
  } state_t;

  state_t          state;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [RW-1:0]   acc;

  // Operand halves derived from the captured operands.
  logic [H-1:0]    a_lo;
  logic [H-1:0]    a_hi;
  logic [H-1:0]    b_lo;
  logic [H-1:0]    b_hi;
  logic [H-1:0]    a_mid;
  logic [H-1:0]    b_mid;

  // Returned sub-product positioned at the three overlap offsets.
  logic [RW-1:0]   p_at_0;
  logic [RW-1:0]   p_at_h;
  logic [RW-1:0]   p_at_2h;

  assign a_lo  = a_reg[H-1:0];
  assign b_lo  = b_reg[H-1:0];
  assign a_hi  = H'(a_reg[N-1:H]);
  assign b_hi  = H'(b_reg[N-1:H]);
  assign a_mid = a_lo ^ a_hi;
  assign b_mid = b_lo ^ b_hi;

  // The top PW-(RW-2H) bits of a product placed at offset 2H would land above
  // bit 2N-2; for a legal HI product (degree <= 2(N-H)-2) they are always zero.
  assign p_at_0  = RW'(sub_p);
  assign p_at_h  = RW'(sub_p) << H;
  assign p_at_2h = {sub_p[RW-2*H-1:0], {(2*H){1'b0}}};

  // Sequencer: issues LO, HI, MID requests in turn, folds each product into
  // the accumulator and publishes the final product with a one-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      sub_valid <= 1'b0;
      sub_a     <= '0;
      sub_b     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            acc       <= '0;
            busy      <= 1'b1;
            sub_valid <= 1'b1;
            sub_a     <= op_a[H-1:0];
            sub_b     <= op_b[H-1:0];
            state     <= REQ_LO;
          end
        end

        // Request states hold sub_a/sub_b untouched until accepted.
        REQ_LO: begin
          if (sub_ready) begin
            sub_valid <= 1'b0;
            state     <= WAIT_LO;
          end
        end

        REQ_HI: begin
          if (sub_ready) begin
            sub_valid <= 1'b0;
            state     <= WAIT_HI;
          end
        end

        REQ_MID: begin
          if (sub_ready) begin
            sub_valid <= 1'b0;
            state     <= WAIT_MID;
          end
        end

        // LO contributes to both the low word and the middle term.
        WAIT_LO: begin
          if (sub_p_valid) begin
            acc       <= acc ^ p_at_0 ^ p_at_h;
            sub_valid <= 1'b1;
            sub_a     <= a_hi;
            sub_b     <= b_hi;
            state     <= REQ_HI;
          end
        end

        // HI contributes to both the middle term and the high word.
        WAIT_HI: begin
          if (sub_p_valid) begin
            acc       <= acc ^ p_at_h ^ p_at_2h;
            sub_valid <= 1'b1;
            sub_a     <= a_mid;
            sub_b     <= b_mid;
            state     <= REQ_MID;
          end
        end

        // MID completes the middle term: (AL+AH)(BL+BH) + LO + HI.
        WAIT_MID: begin
          if (sub_p_valid) begin
            acc   <= acc ^ p_at_h;
            state <= FINISH;
          end
        end

        FINISH: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
